// File: rtl/fetch_pkg.sv
// Shared defaults and state encoding for the instruction fetch controller.
// States are plain constants so legacy code can compare against raw codes.
package fetch_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 10;
  localparam logic [9:0] DEF_HALT_WORD = 10'b0010000010;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'b00;
  localparam state_t ST_FETCH = 2'b01;
  localparam state_t ST_HALT  = 2'b10;

endpackage

// File: rtl/rom_fetch_ctrl.sv
// Sequential fetch unit driving an external combinational-read instruction ROM.
// The PC is presented directly as the ROM address; the read word is captured one cycle later.
module rom_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int                ADDR_W    = DEF_ADDR_W,
  parameter int                DATA_W    = DEF_DATA_W,
  parameter logic [DATA_W-1:0] HALT_WORD = DATA_W'(DEF_HALT_WORD)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] instr_addr,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  state_t            state_r;
  logic [ADDR_W-1:0] pc_r;
  logic [DATA_W-1:0] instr_r;
  logic [ADDR_W-1:0] instr_addr_r;
  logic              instr_valid_r;
  logic              halted_r;

  // Fetch state machine with PC and instruction registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      pc_r          <= '0;
      instr_r       <= '0;
      instr_addr_r  <= '0;
      instr_valid_r <= 1'b0;
      halted_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          instr_valid_r <= 1'b0;
          if (start) begin
            pc_r    <= start_addr;
            state_r <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          // Redirect flushes even a stalled or halting fetch.
          if (redirect_valid) begin
            pc_r          <= redirect_addr;
            instr_valid_r <= 1'b0;
          end else if (!stall) begin
            instr_r       <= rom_data;
            instr_addr_r  <= pc_r;
            instr_valid_r <= 1'b1;
            if (rom_data == HALT_WORD) begin
              state_r  <= ST_HALT;
              halted_r <= 1'b1;
            end else begin
              pc_r <= pc_r + ADDR_W'(1);
            end
          end
        end
        ST_HALT: begin
          instr_valid_r <= 1'b0;
          if (start) begin
            pc_r     <= start_addr;
            halted_r <= 1'b0;
            state_r  <= ST_FETCH;
          end
        end
        default: begin
          state_r       <= ST_IDLE;
          instr_valid_r <= 1'b0;
          halted_r      <= 1'b0;
        end
      endcase
    end
  end

  assign rom_addr    = pc_r;
  assign pc          = pc_r;
  assign instr       = instr_r;
  assign instr_addr  = instr_addr_r;
  assign instr_valid = instr_valid_r;
  assign halted      = halted_r;

endmodule

// File: tb/tb_rom_fetch_ctrl.sv
// Directed bench for rom_fetch_ctrl with a behavioural combinational ROM.
module tb_rom_fetch_ctrl;

  logic       clk;
  logic       reset;
  logic       start;
  logic [9:0] start_addr;
  logic       stall;
  logic       redirect_valid;
  logic [9:0] redirect_addr;
  logic [9:0] rom_addr;
  logic [9:0] rom_data;
  logic [9:0] instr;
  logic       instr_valid;
  logic [9:0] instr_addr;
  logic [9:0] pc;
  logic       halted;

  logic [9:0] rom_mem [1024];
  int vecs;
  int errs;

  rom_fetch_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .start_addr     (start_addr),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .instr          (instr),
    .instr_valid    (instr_valid),
    .instr_addr     (instr_addr),
    .pc             (pc),
    .halted         (halted)
  );

  assign rom_data = rom_mem[rom_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string step, input logic exp_valid, input logic [9:0] exp_instr,
                         input logic [9:0] exp_iaddr, input logic [9:0] exp_pc, input logic exp_halted);
    chk({step, ".instr_valid"}, {31'd0, instr_valid}, {31'd0, exp_valid});
    if (exp_valid) begin
      chk({step, ".instr"}, {22'd0, instr}, {22'd0, exp_instr});
      chk({step, ".instr_addr"}, {22'd0, instr_addr}, {22'd0, exp_iaddr});
    end
    chk({step, ".pc"}, {22'd0, pc}, {22'd0, exp_pc});
    chk({step, ".rom_addr"}, {22'd0, rom_addr}, {22'd0, exp_pc});
    chk({step, ".halted"}, {31'd0, halted}, {31'd0, exp_halted});
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    for (int i = 0; i < 1024; i++) rom_mem[i] = 10'(i + 256);
    rom_mem[0]  = 10'h310;
    rom_mem[1]  = 10'h319;
    rom_mem[2]  = 10'h1D5;
    rom_mem[3]  = 10'h000;
    rom_mem[17] = 10'h082;

    reset = 1'b1;
    start = 1'b0;
    start_addr = 10'd0;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr = 10'd0;

    // reset state
    #2;
    chk("rst.instr", {22'd0, instr}, 32'd0);
    chk("rst.instr_addr", {22'd0, instr_addr}, 32'd0);
    chk_all("rst", 1'b0, 10'd0, 10'd0, 10'd0, 1'b0);

    // first start right after release, start_addr 0
    @(negedge clk);
    reset = 1'b0;
    start = 1'b1;
    start_addr = 10'd0;
    tick();
    start = 1'b0;
    chk_all("start0", 1'b0, 10'd0, 10'd0, 10'd0, 1'b0);
    tick(); chk_all("seq0", 1'b1, 10'h310, 10'd0, 10'd1, 1'b0);
    tick(); chk_all("seq1", 1'b1, 10'h319, 10'd1, 10'd2, 1'b0);
    tick(); chk_all("seq2", 1'b1, 10'h1D5, 10'd2, 10'd3, 1'b0);

    // stall for three cycles
    stall = 1'b1;
    for (int s = 0; s < 3; s++) begin
      tick(); chk_all("stall", 1'b1, 10'h1D5, 10'd2, 10'd3, 1'b0);
    end
    stall = 1'b0;
    tick(); chk_all("zero_word", 1'b1, 10'h000, 10'd3, 10'd4, 1'b0);
    for (int a = 4; a < 16; a++) begin
      tick(); chk_all("run", 1'b1, 10'(a + 256), 10'(a), 10'(a + 1), 1'b0);
    end

    // redirect together with stall at pc 16
    redirect_valid = 1'b1;
    redirect_addr = 10'd10;
    stall = 1'b1;
    tick();
    redirect_valid = 1'b0;
    stall = 1'b0;
    chk_all("redirect", 1'b0, 10'd0, 10'd0, 10'd10, 1'b0);
    tick(); chk_all("post_redir", 1'b1, 10'(266), 10'd10, 10'd11, 1'b0);

    // start during FETCH is ignored
    start = 1'b1;
    start_addr = 10'd500;
    tick();
    start = 1'b0;
    chk_all("start_in_fetch", 1'b1, 10'(267), 10'd11, 10'd12, 1'b0);

    // asynchronous reset between edges at pc 12
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst.instr", {22'd0, instr}, 32'd0);
    chk("async_rst.instr_addr", {22'd0, instr_addr}, 32'd0);
    chk_all("async_rst", 1'b0, 10'd0, 10'd0, 10'd0, 1'b0);
    tick();
    reset = 1'b0;
    for (int s = 0; s < 3; s++) begin
      tick(); chk_all("idle_after_rst", 1'b0, 10'd0, 10'd0, 10'd0, 1'b0);
    end

    // halt detection at address 17
    start = 1'b1;
    start_addr = 10'd16;
    tick();
    start = 1'b0;
    chk_all("start16", 1'b0, 10'd0, 10'd0, 10'd16, 1'b0);
    tick(); chk_all("fetch16", 1'b1, 10'(272), 10'd16, 10'd17, 1'b0);
    tick(); chk_all("halt_enter", 1'b1, 10'h082, 10'd17, 10'd17, 1'b1);
    redirect_valid = 1'b1;
    redirect_addr = 10'd5;
    stall = 1'b1;
    tick();
    chk_all("halt_hold1", 1'b0, 10'd0, 10'd0, 10'd17, 1'b1);
    chk("halt_hold1.instr", {22'd0, instr}, 32'h082);
    tick(); chk_all("halt_hold2", 1'b0, 10'd0, 10'd0, 10'd17, 1'b1);
    redirect_valid = 1'b0;
    stall = 1'b0;

    // restart from HALT at 0
    start = 1'b1;
    start_addr = 10'd0;
    tick();
    start = 1'b0;
    chk_all("restart", 1'b0, 10'd0, 10'd0, 10'd0, 1'b0);
    tick(); chk_all("restart_f0", 1'b1, 10'h310, 10'd0, 10'd1, 1'b0);

    // PC wrap from 1022
    reset = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b1;
    start_addr = 10'd1022;
    tick();
    start = 1'b0;
    chk_all("start1022", 1'b0, 10'd0, 10'd0, 10'd1022, 1'b0);
    tick(); chk_all("wrap1022", 1'b1, 10'h0FE, 10'd1022, 10'd1023, 1'b0);
    tick(); chk_all("wrap1023", 1'b1, 10'h0FF, 10'd1023, 10'd0, 1'b0);
    tick(); chk_all("wrap0", 1'b1, 10'h310, 10'd0, 10'd1, 1'b0);
    tick(); chk_all("wrap1", 1'b1, 10'h319, 10'd1, 10'd2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
